nf10_rr_input_arbiter: RTL and testbench

- Packet-granular round-robin arbiter merging five AXI4-Stream ingress ports into one stream.
- Sits directly upstream of the BRAM output queues and feeds their slave stream port.
- Once a port is granted, it holds the output until that packet's tlast beat completes. Beats of different packets never interleave.
- tuser, including the DST bits [31:24], passes through unmodified.

---
 rtl/nf10_rr_input_arbiter.sv | 175 +++++++++++++++++
 tb/tb_nf10_rr_input_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf10_rr_input_arbiter.sv
// nf10_rr_input_arbiter
//   Packet-granular round-robin merge of five AXI4-Stream ingress ports into
//   one egress stream. A granted port owns the output until its tlast beat
//   transfers; the forward path is purely combinational (zero latency, no
//   buffering), so back-pressure reaches only the selected input.
// Ports:
//   axi_aclk, axi_reset      clock, synchronous active-high reset
//   s_axis_*_0..4            slave (ingress) streams
//   m_axis_*                 master (egress) stream, tuser passed through as-is
module nf10_rr_input_arbiter #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES           = 5
) (
  input  logic                              axi_aclk,
  input  logic                              axi_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_0,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
  input  logic                              s_axis_tvalid_0,
  output logic                              s_axis_tready_0,
  input  logic                              s_axis_tlast_0,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_1,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
  input  logic                              s_axis_tvalid_1,
  output logic                              s_axis_tready_1,
  input  logic                              s_axis_tlast_1,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_2,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_2,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_2,
  input  logic                              s_axis_tvalid_2,
  output logic                              s_axis_tready_2,
  input  logic                              s_axis_tlast_2,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_3,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_3,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_3,
  input  logic                              s_axis_tvalid_3,
  output logic                              s_axis_tready_3,
  input  logic                              s_axis_tlast_3,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_4,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_4,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_4,
  input  logic                              s_axis_tvalid_4,
  output logic                              s_axis_tready_4,
  input  logic                              s_axis_tlast_4,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast
);

  localparam int SW = C_S_AXIS_DATA_WIDTH/8;

  typedef enum logic {IDLE, PKT} state_e;

  state_e     state_q, state_d;
  logic [2:0] cur_port_q, cur_port_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_QUEUES-1:0][C_S_AXIS_DATA_WIDTH-1:0]  in_tdata;
  logic [NUM_QUEUES-1:0][SW-1:0]                   in_tstrb;
  logic [NUM_QUEUES-1:0][C_S_AXIS_TUSER_WIDTH-1:0] in_tuser;
  logic [NUM_QUEUES-1:0]                           in_tvalid, in_tlast, rdy;

  assign in_tdata  = {s_axis_tdata_4, s_axis_tdata_3, s_axis_tdata_2, s_axis_tdata_1, s_axis_tdata_0};
  assign in_tstrb  = {s_axis_tstrb_4, s_axis_tstrb_3, s_axis_tstrb_2, s_axis_tstrb_1, s_axis_tstrb_0};
  assign in_tuser  = {s_axis_tuser_4, s_axis_tuser_3, s_axis_tuser_2, s_axis_tuser_1, s_axis_tuser_0};
  assign in_tvalid = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
  assign in_tlast  = {s_axis_tlast_4, s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};

  function automatic logic [2:0] next_port(input logic [2:0] p);
    return (p >= 3'(NUM_QUEUES-1)) ? 3'd0 : p + 3'd1;
  endfunction

  // Rotating-priority search starting at rr_ptr; out-of-range pointers act as 0.
  logic [2:0] ptr, arb_sel, sel;
  logic [3:0] idx;
  logic       arb_hit, grant_ok;

  always_comb begin
    ptr     = (rr_ptr_q > 3'(NUM_QUEUES-1)) ? 3'd0 : rr_ptr_q;
    arb_hit = 1'b0;
    arb_sel = 3'd0;
    idx     = 4'd0;
    for (int k = 0; k < NUM_QUEUES; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(NUM_QUEUES)) idx = idx - 4'(NUM_QUEUES);
      if (!arb_hit && in_tvalid[idx[2:0]]) begin
        arb_hit = 1'b1;
        arb_sel = idx[2:0];
      end
    end
  end

  // In PKT the owner stays selected even while its tvalid is low between beats.
  assign sel      = (state_q == PKT) ? cur_port_q : arb_sel;
  assign grant_ok = (state_q == PKT) || arb_hit;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  mux_tdata;
  logic [SW-1:0]                   mux_tstrb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] mux_tuser;
  logic                            mux_tvalid, mux_tlast;

  always_comb begin
    mux_tdata  = in_tdata[0];
    mux_tstrb  = in_tstrb[0];
    mux_tuser  = in_tuser[0];
    mux_tvalid = in_tvalid[0];
    mux_tlast  = in_tlast[0];
    for (int i = 1; i < NUM_QUEUES; i++) begin
      if (sel == 3'(i)) begin
        mux_tdata  = in_tdata[i];
        mux_tstrb  = in_tstrb[i];
        mux_tuser  = in_tuser[i];
        mux_tvalid = in_tvalid[i];
        mux_tlast  = in_tlast[i];
      end
    end
  end

  assign m_axis_tdata  = mux_tdata;
  assign m_axis_tstrb  = mux_tstrb;
  assign m_axis_tuser  = mux_tuser;
  assign m_axis_tlast  = mux_tlast;
  assign m_axis_tvalid = !axi_reset && grant_ok && mux_tvalid;

  always_comb begin
    rdy = '0;
    for (int i = 0; i < NUM_QUEUES; i++)
      rdy[i] = !axi_reset && grant_ok && (sel == 3'(i)) && m_axis_tready;
  end

  assign s_axis_tready_0 = rdy[0];
  assign s_axis_tready_1 = rdy[1];
  assign s_axis_tready_2 = rdy[2];
  assign s_axis_tready_3 = rdy[3];
  assign s_axis_tready_4 = rdy[4];

  logic xfer;
  assign xfer = m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_d    = state_q;
    cur_port_d = cur_port_q;
    rr_ptr_d   = rr_ptr_q;
    if (xfer) begin
      if (mux_tlast) begin
        // Packet done: the port after the one just served gets top priority.
        state_d  = IDLE;
        rr_ptr_d = next_port(sel);
      end else if (state_q == IDLE) begin
        state_d    = PKT;
        cur_port_d = sel;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q    <= IDLE;
      cur_port_q <= 3'd0;
      rr_ptr_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      cur_port_q <= cur_port_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_nf10_rr_input_arbiter.sv
module tb_nf10_rr_input_arbiter;
  localparam int DW = 256;
  localparam int SW = 32;
  localparam int UW = 128;
  localparam int NQ = 5;

  logic clk = 1'b0;
  logic axi_reset = 1'b1;
  logic [NQ-1:0][DW-1:0] s_tdata;
  logic [NQ-1:0][SW-1:0] s_tstrb;
  logic [NQ-1:0][UW-1:0] s_tuser;
  logic [NQ-1:0]         s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid, m_tlast;
  logic          m_tready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nf10_rr_input_arbiter dut (
    .axi_aclk(clk), .axi_reset(axi_reset),
    .s_axis_tdata_0(s_tdata[0]), .s_axis_tstrb_0(s_tstrb[0]), .s_axis_tuser_0(s_tuser[0]),
    .s_axis_tvalid_0(s_tvalid[0]), .s_axis_tready_0(s_tready[0]), .s_axis_tlast_0(s_tlast[0]),
    .s_axis_tdata_1(s_tdata[1]), .s_axis_tstrb_1(s_tstrb[1]), .s_axis_tuser_1(s_tuser[1]),
    .s_axis_tvalid_1(s_tvalid[1]), .s_axis_tready_1(s_tready[1]), .s_axis_tlast_1(s_tlast[1]),
    .s_axis_tdata_2(s_tdata[2]), .s_axis_tstrb_2(s_tstrb[2]), .s_axis_tuser_2(s_tuser[2]),
    .s_axis_tvalid_2(s_tvalid[2]), .s_axis_tready_2(s_tready[2]), .s_axis_tlast_2(s_tlast[2]),
    .s_axis_tdata_3(s_tdata[3]), .s_axis_tstrb_3(s_tstrb[3]), .s_axis_tuser_3(s_tuser[3]),
    .s_axis_tvalid_3(s_tvalid[3]), .s_axis_tready_3(s_tready[3]), .s_axis_tlast_3(s_tlast[3]),
    .s_axis_tdata_4(s_tdata[4]), .s_axis_tstrb_4(s_tstrb[4]), .s_axis_tuser_4(s_tuser[4]),
    .s_axis_tvalid_4(s_tvalid[4]), .s_axis_tready_4(s_tready[4]), .s_axis_tlast_4(s_tlast[4]),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
  );

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [UW-1:0] rnd128();
    logic [UW-1:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic clr_inputs();
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tuser  = '0;
    m_tready = 1'b1;
  endtask

  // Holds reset across one rising edge; returns at a falling edge with reset low.
  task automatic do_reset();
    @(negedge clk);
    axi_reset = 1'b1;
    clr_inputs();
    @(negedge clk);
    axi_reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    axi_reset = 1'b1;
    s_tvalid  = 5'h1f;
    s_tlast   = 5'h1f;
    m_tready  = 1'b1;
    #1;
    total++;
    if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", m_tvalid); end
    total++;
    if (s_tready !== 5'b0) begin bad++; $display("FAIL reset_tready got=%b want=00000", s_tready); end
    @(negedge clk);
    total++;
    if (dut.rr_ptr_q !== 3'd0 || dut.cur_port_q !== 3'd0) begin
      bad++; $display("FAIL reset_regs got rr=%0d cur=%0d want 0/0", dut.rr_ptr_q, dut.cur_port_q);
    end
    axi_reset = 1'b0;
    clr_inputs();
  endtask

  // Port 2 sends a 3-beat packet at full rate.
  task automatic test_single_pkt();
    int rcnt = 0;
    do_reset();
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      s_tvalid[2] = 1'b1;
      s_tdata[2]  = DW'(8'hA0 + b);
      s_tlast[2]  = (b == 2);
      #1;
      rcnt += int'(s_tready[2]);
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== DW'(8'hA0 + b) || m_tlast !== (b == 2)) begin
        bad++; $display("FAIL single_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                        b, m_tvalid, m_tdata[7:0], m_tlast, 8'(8'hA0 + b), b == 2);
      end
    end
    @(negedge clk);
    s_tvalid = '0;
    #1;
    rcnt += int'(s_tready[2]);
    total++;
    if (m_tvalid !== 1'b0) begin bad++; $display("FAIL single_after got v=%b want 0", m_tvalid); end
    total++;
    if (rcnt != 3) begin bad++; $display("FAIL single_ready_cycles got=%0d want=3", rcnt); end
    total++;
    if (dut.rr_ptr_q !== 3'd3) begin bad++; $display("FAIL single_rr_ptr got=%0d want=3", dut.rr_ptr_q); end
  endtask

  // Every port has two 2-beat packets queued from reset.
  task automatic test_all_ports();
    int bi[NQ];
    logic [NQ-1:0] take = '0;
    int port, exp;
    do_reset();
    for (int p = 0; p < NQ; p++) bi[p] = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      for (int p = 0; p < NQ; p++) begin
        if (take[p]) bi[p]++;
        s_tvalid[p] = (bi[p] < 4);
        s_tdata[p]  = DW'(p * 16 + bi[p]);
        s_tlast[p]  = (bi[p] % 2 == 1);
      end
      #1;
      port = (n / 2) % NQ;
      exp  = port * 16 + ((n / 2) >= NQ ? 2 : 0) + n % 2;
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== DW'(exp) || m_tlast !== (n % 2 == 1)) begin
        bad++; $display("FAIL all_ports_slot%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                        n, m_tvalid, m_tdata[7:0], m_tlast, 8'(exp), n % 2 == 1);
      end
      take = s_tvalid & s_tready;
    end
    @(negedge clk);
    clr_inputs();
  endtask

  // Port 0 requests while port 1 owns the output.
  task automatic test_no_interleave();
    do_reset();
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      s_tvalid[1] = (s < 3);
      s_tdata[1]  = DW'(12'h110 + s);
      s_tlast[1]  = (s == 2);
      s_tvalid[0] = (s >= 1);
      s_tdata[0]  = DW'(12'h0AA);
      s_tlast[0]  = 1'b1;
      #1;
      if (s < 3) begin
        total++;
        if (m_tdata !== DW'(12'h110 + s) || s_tready !== 5'b00010) begin
          bad++; $display("FAIL interleave_slot%0d got d=%h rdy=%b want d=%h rdy=00010",
                          s, m_tdata[11:0], s_tready, 12'(12'h110 + s));
        end
      end else begin
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== DW'(12'h0AA) || s_tready !== 5'b00001) begin
          bad++; $display("FAIL interleave_port0 got v=%b d=%h rdy=%b want v=1 d=0aa rdy=00001",
                          m_tvalid, m_tdata[11:0], s_tready);
        end
      end
    end
    @(negedge clk);
    clr_inputs();
  endtask

  // Output stall with tready 1,0,0,1,1,1 during a 4-beat packet from port 3.
  task automatic test_backpressure();
    logic [DW-1:0] d[4];
    logic [UW-1:0] u[4];
    logic tr[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int b = 0;
    logic take = 1'b0;
    for (int i = 0; i < 4; i++) begin d[i] = rnd256(); u[i] = rnd128(); end
    do_reset();
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      if (take) b++;
      m_tready    = tr[s];
      s_tvalid[3] = 1'b1;
      s_tdata[3]  = d[b];
      s_tuser[3]  = u[b];
      s_tlast[3]  = (b == 3);
      #1;
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== d[b] || m_tuser !== u[b] || m_tlast !== (b == 3)) begin
        bad++; $display("FAIL backpressure_slot%0d beat%0d got d=%h u=%h l=%b want d=%h u=%h l=%b",
                        s, b, m_tdata, m_tuser, m_tlast, d[b], u[b], b == 3);
      end
      total++;
      if (s_tready !== (tr[s] ? 5'b01000 : 5'b00000)) begin
        bad++; $display("FAIL backpressure_rdy%0d got=%b want=%b", s, s_tready, tr[s] ? 5'b01000 : 5'b00000);
      end
      take = tr[s];
    end
    total++;
    if (b != 3 || !take) begin bad++; $display("FAIL backpressure_count got=%0d want=3", b); end
    @(negedge clk);
    clr_inputs();
  endtask

  // rr_ptr driven to 4, then ports 4 and 0 send single-beat packets together.
  task automatic test_rr_wrap();
    do_reset();
    @(negedge clk);
    s_tvalid[3] = 1'b1; s_tlast[3] = 1'b1; s_tdata[3] = DW'(8'h33);
    #1;
    total++;
    if (s_tready !== 5'b01000) begin bad++; $display("FAIL wrap_p3 rdy got=%b want=01000", s_tready); end
    @(negedge clk);
    s_tvalid = 5'b10001; s_tlast = 5'b10001;
    s_tdata[4] = DW'(8'h44); s_tdata[0] = DW'(8'h00);
    #1;
    total++;
    if (m_tdata !== DW'(8'h44) || s_tready !== 5'b10000) begin
      bad++; $display("FAIL wrap_first got d=%h rdy=%b want d=44 rdy=10000", m_tdata[7:0], s_tready);
    end
    @(negedge clk);
    s_tvalid[4] = 1'b0;
    #1;
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== DW'(8'h00) || s_tready !== 5'b00001) begin
      bad++; $display("FAIL wrap_second got v=%b d=%h rdy=%b want v=1 d=00 rdy=00001", m_tvalid, m_tdata[7:0], s_tready);
    end
    @(negedge clk);
    s_tvalid = '0;
    #1;
    total++;
    if (dut.rr_ptr_q !== 3'd1) begin bad++; $display("FAIL wrap_rr_ptr got=%0d want=1", dut.rr_ptr_q); end
    clr_inputs();
  endtask

  // One-cycle reset during beat 2 of a 5-beat packet from port 2.
  task automatic test_reset_mid_pkt();
    do_reset();
    @(negedge clk);
    s_tvalid[2] = 1'b1; s_tdata[2] = DW'(8'h20); s_tlast[2] = 1'b0;
    #1;
    total++;
    if (m_tdata !== DW'(8'h20) || s_tready !== 5'b00100) begin
      bad++; $display("FAIL rstmid_beat0 got d=%h rdy=%b want d=20 rdy=00100", m_tdata[7:0], s_tready);
    end
    @(negedge clk);
    axi_reset = 1'b1;
    s_tdata[2] = DW'(8'h21);
    s_tvalid[0] = 1'b1; s_tdata[0] = DW'(8'h0F); s_tlast[0] = 1'b1;
    #1;
    total++;
    if (m_tvalid !== 1'b0 || s_tready !== 5'b0) begin
      bad++; $display("FAIL rstmid_gate got v=%b rdy=%b want v=0 rdy=00000", m_tvalid, s_tready);
    end
    @(negedge clk);
    axi_reset = 1'b0;
    #1;
    total++;
    if (dut.rr_ptr_q !== 3'd0) begin bad++; $display("FAIL rstmid_rr_ptr got=%0d want=0", dut.rr_ptr_q); end
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== DW'(8'h0F) || m_tlast !== 1'b1 || s_tready !== 5'b00001) begin
      bad++; $display("FAIL rstmid_port0 got v=%b d=%h l=%b rdy=%b want v=1 d=0f l=1 rdy=00001",
                      m_tvalid, m_tdata[7:0], m_tlast, s_tready);
    end
    @(negedge clk);
    s_tvalid[0] = 1'b0;
    #1;
    total++;
    if (m_tdata !== DW'(8'h21) || s_tready !== 5'b00100) begin
      bad++; $display("FAIL rstmid_port2 got d=%h rdy=%b want d=21 rdy=00100", m_tdata[7:0], s_tready);
    end
    @(negedge clk);
    clr_inputs();
  endtask

  // Random traffic against a packet-level round-robin reference.
  task automatic test_random();
    int rem[NQ];
    logic [NQ-1:0] take = '0;
    logic [NQ-1:0] exp_r;
    int owner = -1;
    int ptr = 0;
    int g;
    logic exp_v;
    int fails_shown = 0;
    do_reset();
    for (int p = 0; p < NQ; p++) rem[p] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int p = 0; p < NQ; p++) begin
        if (take[p]) begin s_tvalid[p] = 1'b0; rem[p]--; end
        // A beat once offered stays put until it is accepted.
        if (!s_tvalid[p] && ($urandom % 10) < 6) begin
          if (rem[p] == 0) rem[p] = $urandom_range(1, 4);
          s_tvalid[p] = 1'b1;
          s_tdata[p]  = rnd256();
          s_tuser[p]  = rnd128();
          s_tstrb[p]  = $urandom;
          s_tlast[p]  = (rem[p] == 1);
        end
      end
      m_tready = ($urandom % 4) != 0;
      #1;
      g = owner;
      if (g < 0)
        for (int k = 0; k < NQ; k++)
          if (g < 0 && s_tvalid[(ptr + k) % NQ]) g = (ptr + k) % NQ;
      exp_v = (g >= 0) && s_tvalid[g];
      exp_r = '0;
      if (g >= 0 && m_tready) exp_r[g] = 1'b1;
      total++;
      if (m_tvalid !== exp_v || s_tready !== exp_r) begin
        bad++;
        if (fails_shown++ < 10)
          $display("FAIL random_ctl cyc%0d got v=%b rdy=%b want v=%b rdy=%b", c, m_tvalid, s_tready, exp_v, exp_r);
      end
      if (exp_v) begin
        total++;
        if (m_tdata !== s_tdata[g] || m_tuser !== s_tuser[g] || m_tstrb !== s_tstrb[g] || m_tlast !== s_tlast[g]) begin
          bad++;
          if (fails_shown++ < 10)
            $display("FAIL random_data cyc%0d port%0d got d=%h l=%b want d=%h l=%b", c, g, m_tdata, m_tlast, s_tdata[g], s_tlast[g]);
        end
        if (m_tready) begin
          if (s_tlast[g]) begin owner = -1; ptr = (g + 1) % NQ; end
          else owner = g;
        end
      end
      take = s_tvalid & exp_r;
    end
    @(negedge clk);
    clr_inputs();
  endtask

  initial begin
    clr_inputs();
    test_reset();
    test_single_pkt();
    test_all_ports();
    test_no_interleave();
    test_backpressure();
    test_rr_wrap();
    test_reset_mid_pkt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
